// File: rtl/imem_arbiter.sv
// imem_arbiter: zero-fills the 64-word instruction memory after reset or soft_clear,
// then shares the single memory port between CPU fetch (read) and program loader
// (write) with round-robin arbitration and a request/grant handshake.
module imem_arbiter #(
   parameter int unsigned DEPTH  = 64,
   parameter int unsigned ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              soft_clear,
   input  logic              fetch_req,
   input  logic [31:0]       fetch_pc,
   output logic              fetch_gnt,
   output logic              fetch_valid,
   output logic [31:0]       fetch_instr,
   output logic              fetch_err,
   input  logic              load_req,
   input  logic [31:0]       load_addr,
   input  logic [31:0]       load_data,
   output logic              load_gnt,
   output logic              load_done,
   output logic              load_err,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic              init_done
);

   localparam int unsigned DATA_W    = 32;
   localparam logic        GNT_FETCH = 1'b0;
   localparam logic        GNT_LOAD  = 1'b1;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   state_t            state;
   state_t            next_state;
   logic [ADDR_W-1:0] clr_cnt;
   logic              last_gnt;
   logic              fetch_ok;
   logic              load_ok;

   // Aligned and inside the array; upper bits must be zero so nothing aliases
   assign fetch_ok = (fetch_pc[1:0] == 2'b00) && (fetch_pc[DATA_W-1:ADDR_W+2] == '0);
   assign load_ok  = (load_addr[1:0] == 2'b00) && (load_addr[DATA_W-1:ADDR_W+2] == '0);

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_CLEAR;
      end else begin
         state <= next_state;
      end
   end

   // Next-state: clear runs to the last word, soft_clear restarts it from RUN
   always_comb begin
      next_state = state;
      case (state)
         ST_CLEAR: if (clr_cnt == ADDR_W'(DEPTH - 1)) next_state = ST_RUN;
         ST_RUN:   if (soft_clear) next_state = ST_CLEAR;
         default:  next_state = ST_CLEAR;
      endcase
   end

   // Port mux and round-robin grant; no grants during clear or on a soft_clear cycle
   always_comb begin
      fetch_gnt = 1'b0;
      load_gnt  = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (state == ST_CLEAR) begin
         mem_we   = 1'b1;
         mem_addr = clr_cnt;
      end else if (!soft_clear) begin
         if (fetch_req && (!load_req || (last_gnt == GNT_LOAD))) begin
            fetch_gnt = 1'b1;
         end else if (load_req) begin
            load_gnt = 1'b1;
         end
         if (fetch_gnt) begin
            mem_addr = fetch_pc[ADDR_W+1:2];
         end else if (load_gnt) begin
            mem_addr  = load_addr[ADDR_W+1:2];
            mem_wdata = load_data;
            mem_we    = load_ok;
         end
      end
   end

   // Clear counter runs only in CLEAR; last_gnt remembers the most recent winner
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clr_cnt  <= '0;
         last_gnt <= GNT_LOAD;
      end else begin
         if (state == ST_CLEAR) begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
         end else begin
            clr_cnt <= '0;
         end
         if (fetch_gnt) begin
            last_gnt <= GNT_FETCH;
         end else if (load_gnt) begin
            last_gnt <= GNT_LOAD;
         end
      end
   end

   // Registered responses, one cycle after the grant
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_valid <= 1'b0;
         fetch_instr <= '0;
         fetch_err   <= 1'b0;
         load_done   <= 1'b0;
         load_err    <= 1'b0;
         init_done   <= 1'b0;
      end else begin
         fetch_valid <= fetch_gnt;
         fetch_err   <= fetch_gnt & ~fetch_ok;
         if (fetch_gnt) begin
            fetch_instr <= fetch_ok ? mem_rdata : '0;
         end
         load_done <= load_gnt;
         load_err  <= load_gnt & ~load_ok;
         init_done <= (next_state == ST_RUN);
      end
   end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed testbench for imem_arbiter with a behavioural 64-word memory model.
module tb_imem_arbiter;

   localparam int unsigned DEPTH  = 64;
   localparam int unsigned ADDR_W = 6;

   logic              clk = 1'b0;
   logic              rst;
   logic              soft_clear;
   logic              fetch_req;
   logic [31:0]       fetch_pc;
   logic              fetch_gnt;
   logic              fetch_valid;
   logic [31:0]       fetch_instr;
   logic              fetch_err;
   logic              load_req;
   logic [31:0]       load_addr;
   logic [31:0]       load_data;
   logic              load_gnt;
   logic              load_done;
   logic              load_err;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic              init_done;

   logic [31:0] mem [DEPTH];

   int n_checks = 0;
   int n_fail   = 0;

   imem_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .soft_clear (soft_clear),
      .fetch_req  (fetch_req),
      .fetch_pc   (fetch_pc),
      .fetch_gnt  (fetch_gnt),
      .fetch_valid(fetch_valid),
      .fetch_instr(fetch_instr),
      .fetch_err  (fetch_err),
      .load_req   (load_req),
      .load_addr  (load_addr),
      .load_data  (load_data),
      .load_gnt   (load_gnt),
      .load_done  (load_done),
      .load_err   (load_err),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .init_done  (init_done)
   );

   always #5 clk = ~clk;

   // Memory model: combinational read, synchronous write
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
   end
   assign mem_rdata = mem[mem_addr];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      fetch_req  = 1'b0;
      load_req   = 1'b0;
      soft_clear = 1'b0;
   endtask

   // Expects CLEAR at counter 0 now; walks all words and ends just after RUN is entered
   task automatic check_clear(input string tag);
      for (int i = 0; i < DEPTH; i++) begin
         #1;
         check_val({tag, "_we"},    32'(mem_we),    32'd1);
         check_val({tag, "_addr"},  32'(mem_addr),  32'(i));
         check_val({tag, "_wdata"}, mem_wdata,      32'd0);
         check_val({tag, "_init"},  32'(init_done), 32'd0);
         check_val({tag, "_gnt"},   32'({fetch_gnt, load_gnt}), 32'd0);
         step();
      end
      #1;
      check_val({tag, "_init_done"}, 32'(init_done), 32'd1);
   endtask

   initial begin
      rst       = 1'b0;
      idle();
      fetch_pc  = '0;
      load_addr = '0;
      load_data = '0;

      // Reset values, with requests pending
      fetch_req = 1'b1;
      load_req  = 1'b1;
      #2;
      check_val("rst_fetch_valid", 32'(fetch_valid), 32'd0);
      check_val("rst_fetch_instr", fetch_instr,      32'd0);
      check_val("rst_fetch_err",   32'(fetch_err),   32'd0);
      check_val("rst_load_done",   32'(load_done),   32'd0);
      check_val("rst_load_err",    32'(load_err),    32'd0);
      check_val("rst_init_done",   32'(init_done),   32'd0);
      check_val("rst_gnt",         32'({fetch_gnt, load_gnt}), 32'd0);
      check_val("rst_mem_we",      32'(mem_we),      32'd1);
      check_val("rst_mem_addr",    32'(mem_addr),    32'd0);
      check_val("rst_mem_wdata",   mem_wdata,        32'd0);
      idle();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      check_clear("init");
      check_val("run_idle_we", 32'(mem_we), 32'd0);

      // Both requesting: F, L, F, L starting from last_gnt = LOAD
      fetch_req = 1'b1; fetch_pc  = 32'h0;
      load_req  = 1'b1; load_addr = 32'h20; load_data = 32'h1111_1111;
      for (int k = 0; k < 4; k++) begin
         #1;
         check_val("arb_fetch_gnt", 32'(fetch_gnt), 32'((k % 2) == 0));
         check_val("arb_load_gnt",  32'(load_gnt),  32'((k % 2) == 1));
         step();
         #1;
         check_val("arb_fetch_valid", 32'(fetch_valid), 32'((k % 2) == 0));
         check_val("arb_load_done",   32'(load_done),   32'((k % 2) == 1));
      end
      idle();
      check_val("arb_mem8", mem[8], 32'h1111_1111);

      // Load 0xDEADBEEF to 0x10, then fetch it back the next cycle
      load_req = 1'b1; load_addr = 32'h10; load_data = 32'hDEAD_BEEF;
      #1;
      check_val("ld_gnt",   32'(load_gnt),  32'd1);
      check_val("ld_we",    32'(mem_we),    32'd1);
      check_val("ld_addr",  32'(mem_addr),  32'd4);
      check_val("ld_wdata", mem_wdata,      32'hDEAD_BEEF);
      step();
      load_req = 1'b0;
      fetch_req = 1'b1; fetch_pc = 32'h10;
      #1;
      check_val("ld_done",   32'(load_done), 32'd1);
      check_val("ld_err",    32'(load_err),  32'd0);
      check_val("fe_gnt",    32'(fetch_gnt), 32'd1);
      check_val("fe_addr",   32'(mem_addr),  32'd4);
      check_val("fe_we",     32'(mem_we),    32'd0);
      step();
      fetch_req = 1'b0;
      #1;
      check_val("fe_valid", 32'(fetch_valid), 32'd1);
      check_val("fe_instr", fetch_instr,      32'hDEAD_BEEF);
      check_val("fe_err",   32'(fetch_err),   32'd0);
      check_val("ld_done_pulse", 32'(load_done), 32'd0);

      // Bad fetch address
      fetch_req = 1'b1; fetch_pc = 32'h102;
      #1;
      check_val("bad_fe_gnt", 32'(fetch_gnt), 32'd1);
      step();
      fetch_req = 1'b0;
      #1;
      check_val("bad_fe_valid", 32'(fetch_valid), 32'd1);
      check_val("bad_fe_err",   32'(fetch_err),   32'd1);
      check_val("bad_fe_instr", fetch_instr,      32'd0);

      // Word 0 gets a marker, then an out-of-range load must not alias onto it
      load_req = 1'b1; load_addr = 32'h0; load_data = 32'hCAFE_F00D;
      step();
      load_addr = 32'h100; load_data = 32'h0BAD_0BAD;
      #1;
      check_val("bad_ld_gnt", 32'(load_gnt), 32'd1);
      check_val("bad_ld_we",  32'(mem_we),   32'd0);
      step();
      load_req = 1'b0;
      #1;
      check_val("bad_ld_done", 32'(load_done), 32'd1);
      check_val("bad_ld_err",  32'(load_err),  32'd1);
      check_val("bad_ld_mem0", mem[0],         32'hCAFE_F00D);
      fetch_req = 1'b1; fetch_pc = 32'h0;
      step();
      fetch_req = 1'b0;
      #1;
      check_val("w0_valid", 32'(fetch_valid), 32'd1);
      check_val("w0_err",   32'(fetch_err),   32'd0);
      check_val("w0_instr", fetch_instr,      32'hCAFE_F00D);

      // soft_clear after loading word 5; fetch held through the clear
      load_req = 1'b1; load_addr = 32'h14; load_data = 32'h1234_5678;
      step();
      load_req = 1'b0;
      #1;
      check_val("sc_mem5", mem[5], 32'h1234_5678);
      soft_clear = 1'b1;
      fetch_req  = 1'b1; fetch_pc = 32'h14;
      #1;
      check_val("sc_no_gnt", 32'({fetch_gnt, load_gnt}), 32'd0);
      check_val("sc_no_we",  32'(mem_we), 32'd0);
      step();
      soft_clear = 1'b0;
      check_clear("soft");
      check_val("sc_first_gnt", 32'(fetch_gnt), 32'd1);
      step();
      fetch_req = 1'b0;
      #1;
      check_val("sc_valid", 32'(fetch_valid), 32'd1);
      check_val("sc_instr", fetch_instr,      32'd0);
      check_val("sc_err",   32'(fetch_err),   32'd0);

      // Reset in the middle of a clear restarts it from word 0
      soft_clear = 1'b1;
      step();
      soft_clear = 1'b0;
      repeat (20) step();
      #1;
      check_val("mid_addr20", 32'(mem_addr), 32'd20);
      rst = 1'b0;
      #1;
      check_val("mid_rst_addr", 32'(mem_addr),  32'd0);
      check_val("mid_rst_we",   32'(mem_we),    32'd1);
      check_val("mid_rst_init", 32'(init_done), 32'd0);
      step();
      step();
      check_val("mid_rst_hold", 32'(mem_addr), 32'd0);
      rst = 1'b1;
      check_clear("rst_clr");

      // Asynchronous reset drops an in-flight fetch_valid pulse
      fetch_req = 1'b1; fetch_pc = 32'h0;
      @(posedge clk);
      #1;
      fetch_req = 1'b0;
      check_val("drop_valid_pre", 32'(fetch_valid), 32'd1);
      rst = 1'b0;
      #1;
      check_val("drop_valid", 32'(fetch_valid), 32'd0);
      check_val("drop_init",  32'(init_done),   32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
